// File: rtl/regfile_burst_reader.sv
// regfile_burst_reader: walks a contiguous, wrap-around address range on a
// register file's combinational read port. The words leave on a registered
// valid/ready stream at up to one word per cycle.
//
// Stream handshake: a word transfers on every rising edge where m_valid and
// m_ready are both high. m_data and m_last stay constant while m_valid is high
// and m_ready is low. m_valid drops only on the edge that completes a
// handshake.
//
// Optional build: define REGFILE_BURST_READER_CHECKSUM_EN to add a `checksum`
// output. It holds the XOR of every word accepted in the current or most
// recent burst.
//
// dbg_state exposes the FSM encoding (0 = IDLE, 1 = RUN, 2 = DRAIN) for
// external checkers.

module regfile_burst_reader #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  start_addr,
  input  logic [ADDR_BITS:0]    length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  rf_rdaddr,
  input  logic [DATA_WIDTH-1:0] rf_dataout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            dbg_state,
  output logic                  m_last
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [ADDR_BITS:0]   DEPTH_C   = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);
  localparam logic [ADDR_BITS:0]   ONE_REM   = (ADDR_BITS + 1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [ADDR_BITS:0]      rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;
`endif

  // Helper terms: handshake, load condition, normalised start address.
  logic                    handshake;
  logic                    load;
  logic [ADDR_BITS:0]      start_ext;
  logic [ADDR_BITS-1:0]    start_norm;
  logic [ADDR_BITS-1:0]    addr_next;

  assign handshake = valid_q & m_ready;
  // The output register can take a new word if it is empty or is being
  // emptied on this edge.
  assign load      = (state_q == S_RUN) && (!valid_q || m_ready);
  assign start_ext = {1'b0, start_addr};
  // start_addr < 2*DEPTH always holds, so a single subtraction is a full modulo.
  assign start_norm = (start_ext >= DEPTH_C) ? ADDR_BITS'(start_ext - DEPTH_C)
                                             : start_addr;
  assign addr_next  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_BITS'(1);

  // Next-state and datapath decode; every target defaults to a hold.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
    csum_d  = handshake ? (csum_q ^ data_q) : csum_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
          csum_d = '0;
`endif
          if (length != '0) begin
            addr_d  = start_norm;
            rem_d   = (length > DEPTH_C) ? DEPTH_C : length;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (load) begin
          data_d  = rf_dataout;
          valid_d = 1'b1;
          last_d  = (rem_q == ONE_REM);
          addr_d  = addr_next;
          rem_d   = rem_q - ONE_REM;
          if (rem_q == ONE_REM) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (handshake) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset; reset abandons any burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign rf_rdaddr = addr_q;
  assign m_valid   = valid_q;
  assign m_data    = data_q;
  assign m_last    = last_q;
  assign dbg_state = state_q;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader. A register file model feeds the
// read port. A scoreboard queue holds the words each burst should emit.
module tb_regfile_burst_reader;

  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int AB    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AB-1:0] start_addr = '0;
  logic [AB:0]   length = '0;
  logic          busy, done, m_valid, m_last;
  logic          m_ready = 1'b1;
  logic [AB-1:0] rf_rdaddr;
  logic [DW-1:0] rf_dataout, m_data;
  logic [1:0]    dbg_state;
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  logic [DW-1:0] rf_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            n_cmp = 0;
  int            n_err = 0;

  assign rf_dataout = rf_mem[rf_rdaddr];

  // clock / reset
  always #5 clk = ~clk;

  regfile_burst_reader #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .rf_rdaddr(rf_rdaddr),
    .rf_dataout(rf_dataout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .dbg_state(dbg_state), .m_last(m_last)
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one burst and checks it. Outputs are sampled on the falling edge.
  // rdy_pat[k] drives m_ready on the k-th cycle that m_valid is high; after
  // npat cycles m_ready stays high. noise: start is held high with other
  // parameters while busy. pre: start is driven now (done cycle of the
  // previous burst) instead of one negedge later. chain: return at the
  // done negedge so the next burst can start in that cycle.
  task automatic run_burst(input string tag, input int sa, input int len,
                           input logic [15:0] rdy_pat, input int npat,
                           input bit noise, input bit pre, input bit chain);
    int            n_exp;
    int            pidx;
    int            beats;
    bit            stalled;
    bit            hs_prev;
    bit            fin;
    bit            r;
    logic [DW-1:0] held_d;
    logic          held_l;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] exp_x;
    n_exp = (len > DEPTH) ? DEPTH : len;
    exp_q.delete();
    exp_x = '0;
    for (int i = 0; i < n_exp; i++) exp_q.push_back(rf_mem[(sa + i) % DEPTH]);
    if (!pre) @(negedge clk);
    start = 1'b1; start_addr = AB'(sa); length = (AB+1)'(len);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, n_exp != 0);
    check({tag, "_done_after_start"}, done, n_exp == 0);
    check({tag, "_valid_after_start"}, m_valid, 0);
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
    check({tag, "_csum_cleared"}, checksum, 0);
`endif
    if (n_exp == 0) begin
      @(negedge clk);
      check({tag, "_empty_done_drop"}, done, 0);
      check({tag, "_empty_no_valid"}, m_valid, 0);
      return;
    end
    check({tag, "_rdaddr_first"}, rf_rdaddr, sa % DEPTH);
    check({tag, "_state_run"}, dbg_state, 1);
    pidx = 0; beats = 0; stalled = 0; hs_prev = 0; fin = 0;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      @(negedge clk);
      if (done) begin
        fin = 1;
        start = 1'b0;
        check({tag, "_beats"}, beats, n_exp);
        check({tag, "_done_after_last_hs"}, hs_prev, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_valid_at_done"}, m_valid, 0);
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
        check({tag, "_csum_at_done"}, checksum, exp_x);
`endif
      end else begin
        check({tag, "_valid_no_gap"}, m_valid, 1);
        check({tag, "_busy_mid"}, busy, 1);
        if (stalled) begin
          check({tag, "_stall_data"}, m_data, held_d);
          check({tag, "_stall_last"}, m_last, held_l);
        end
        if (noise) begin
          start = 1'b1; start_addr = AB'(17); length = (AB+1)'(5);
        end
        r = 1'b1;
        if (m_valid) begin
          if (pidx < npat) r = rdy_pat[pidx];
          pidx++;
        end
        m_ready = r;
        hs_prev = 0;
        if (m_valid && r) begin
          check({tag, "_beat_in_range"}, beats < n_exp, 1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            exp_x = exp_x ^ exp_w;
            check({tag, "_data"}, m_data, exp_w);
            check({tag, "_last"}, m_last, exp_q.size() == 0);
          end
          beats++;
          hs_prev = 1;
          stalled = 0;
        end else if (m_valid) begin
          stalled = 1;
          held_d = m_data;
          held_l = m_last;
        end
      end
    end
    check({tag, "_done_seen"}, fin, 1);
    if (!chain) begin
      m_ready = 1'b1;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
      check({tag, "_csum_stable"}, checksum, exp_x);
`endif
    end
  endtask

  // Watchdog: stops the run if a wait loop never returns.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed sequence.
  initial begin
    for (int i = 0; i < DEPTH; i++) rf_mem[i] = 32'h100 + i;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_data", m_data, 0);
    check("rst_rdaddr", rf_rdaddr, 0);
    check("rst_state", dbg_state, 0);
`ifdef REGFILE_BURST_READER_CHECKSUM_EN
    check("rst_csum", checksum, 0);
`endif
    rst = 1'b0;

    // Basic burst: 0x104, 0x105, 0x106 back-to-back.
    run_burst("b4x3", 4, 3, 16'h0000, 0, 0, 0, 0);
    // Wrap-around: addresses 30, 31, 0, 1.
    run_burst("wrap", 30, 4, 16'h0000, 0, 0, 0, 0);
    // Backpressure pattern 1,0,0,1,1 with ignored start pulses while busy.
    run_burst("bp", 8, 3, 16'h0019, 5, 1, 0, 0);
    // Empty burst.
    run_burst("len0", 3, 0, 16'h0000, 0, 0, 0, 0);
    // Clamped burst: 40 requested, 32 beats, every entry once.
    run_burst("len40", 5, 40, 16'h0000, 0, 0, 0, 1);
    // Start in the same cycle as the previous done pulse.
    run_burst("chain", 10, 2, 16'h0005, 3, 0, 1, 0);

    // Reset mid-burst after two accepted beats.
    @(negedge clk);
    m_ready = 1'b1; start = 1'b1; start_addr = AB'(0); length = (AB+1)'(8);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_data_b2", m_data, 32'h102);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_data", m_data, 0);
    check("rst_mid_rdaddr", rf_rdaddr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_no_done", done, 0);
    run_burst("after_rst", 20, 6, 16'h0000, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
